rgb_breathe_sched: RTL and testbench

RGB_BREATHE_SCHED -- requirements
Module: rgb_breathe_sched

---
 rtl/rgb_breathe_sched_pkg.sv | 23 ++
 rtl/sched_step_timer.sv | 46 ++++
 rtl/rgb_breathe_sched.sv | 173 +++++++++++++++++
 tb/tb_rgb_breathe_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rgb_breathe_sched_pkg.sv
// Shared types and constants for the RGB breathe step scheduler.
package rgb_breathe_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Dwell reset value, in clk cycles per step
  localparam int unsigned DEFAULT_DWELL = 65536000;

  // Pattern table: 4 entries of {blue,green,red}, 1 = channel held off
  typedef logic [3:0][2:0] tbl_t;

  // Entry 0 sits in the low bits: entries 0..3 = 011, 101, 110, 111
  localparam tbl_t TBL_DEFAULT = {3'b111, 3'b110, 3'b101, 3'b011};

  // All channels held in reset
  localparam logic [2:0] HOLD_ALL = 3'b111;

endpackage

// File: rtl/sched_step_timer.sv
// Step timer: free-running count within a step, compared against the dwell
// value latched at the start of that step.
module sched_step_timer #(
  parameter int unsigned DWELL_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,   // return to idle: count back to 0
  input  logic               load_i,    // start of a step: count 0, latch dwell
  input  logic               run_i,     // count this cycle
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               at_end_o   // count is on the last cycle of the step
);

  logic [DWELL_W-1:0] count_q, count_d;
  logic [DWELL_W-1:0] dwell_cur_q, dwell_cur_d;

  // Last cycle of the step; dwell_cur is never 0 so the subtract cannot wrap
  assign at_end_o = (count_q == (dwell_cur_q - DWELL_W'(1)));

  // Next count / dwell latch; a dwell of 0 is stored as 1
  always_comb begin
    count_d     = count_q;
    dwell_cur_d = dwell_cur_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d     = '0;
      dwell_cur_d = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
    end else if (run_i) begin
      count_d = count_q + DWELL_W'(1);
    end
  end

  // Timer registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q     <= '0;
      dwell_cur_q <= DWELL_W'(1);
    end else begin
      count_q     <= count_d;
      dwell_cur_q <= dwell_cur_d;
    end
  end

endmodule

// File: rtl/rgb_breathe_sched.sv
// RGB breathe scheduler: steps through a 4-entry channel-hold pattern table,
// holding each entry for a programmable number of clk cycles.
//
// Control inputs are plain pulses/levels sampled on every rising edge; there
// is no valid/ready handshake. start and stop are single-cycle pulses (stop
// wins when both are high), pause is a level, and the write strobes act on the
// edge where they are high, with the new value used from the next step load.
module rgb_breathe_sched
  import rgb_breathe_sched_pkg::*;
#(
  parameter int unsigned DWELL_W       = 32,
  parameter int unsigned DEFAULT_DWELL = rgb_breathe_sched_pkg::DEFAULT_DWELL
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop_en,
  input  logic [1:0]         last_step,
  input  logic               tbl_we,
  input  logic [1:0]         tbl_addr,
  input  logic [2:0]         tbl_wdata,
  input  logic               dwell_we,
  input  logic [DWELL_W-1:0] dwell_wdata,
  output logic [2:0]         chan_hold,
  output logic [1:0]         step_idx,
  output logic               step_strobe,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [1:0]         step_idx_q, step_idx_d;
  logic [2:0]         chan_hold_q, chan_hold_d;
  logic               step_strobe_q, step_strobe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  tbl_t               tbl_q, tbl_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               t_clear;
  logic               t_load;
  logic               t_run;
  logic               t_at_end;
  logic [1:0]         next_idx;

  assign next_idx = step_idx_q + 2'd1;

  sched_step_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (t_clear),
    .load_i   (t_load),
    .run_i    (t_run),
    .dwell_i  (dwell_q),
    .at_end_o (t_at_end)
  );

  // Table and dwell register writes; step loads read the pre-write contents
  always_comb begin
    tbl_d   = tbl_q;
    dwell_d = dwell_q;
    if (tbl_we) begin
      tbl_d[tbl_addr] = tbl_wdata;
    end
    if (dwell_we) begin
      dwell_d = dwell_wdata;
    end
  end

  // FSM next state, next registered outputs and timer controls
  always_comb begin
    state_d       = state_q;
    step_idx_d    = step_idx_q;
    chan_hold_d   = chan_hold_q;
    step_strobe_d = 1'b0;
    done_d        = 1'b0;
    t_clear       = 1'b0;
    t_load        = 1'b0;
    t_run         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d     = ST_RUN;
          step_idx_d  = 2'd0;
          chan_hold_d = tbl_q[0];
          t_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d     = ST_IDLE;
          step_idx_d  = 2'd0;
          chan_hold_d = HOLD_ALL;
          t_clear     = 1'b1;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          t_run = 1'b1;
          if (t_at_end) begin
            if (step_idx_q < last_step) begin
              step_idx_d    = next_idx;
              chan_hold_d   = tbl_q[next_idx];
              step_strobe_d = 1'b1;
              t_load        = 1'b1;
            end else if (loop_en) begin
              step_idx_d    = 2'd0;
              chan_hold_d   = tbl_q[0];
              step_strobe_d = 1'b1;
              t_load        = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              step_idx_d  = 2'd0;
              chan_hold_d = HOLD_ALL;
              done_d      = 1'b1;
              t_clear     = 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d     = ST_IDLE;
          step_idx_d  = 2'd0;
          chan_hold_d = HOLD_ALL;
          t_clear     = 1'b1;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        step_idx_d  = 2'd0;
        chan_hold_d = HOLD_ALL;
        t_clear     = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, table, dwell and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      step_idx_q    <= 2'd0;
      chan_hold_q   <= HOLD_ALL;
      step_strobe_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tbl_q         <= TBL_DEFAULT;
      dwell_q       <= DWELL_W'(DEFAULT_DWELL);
    end else begin
      state_q       <= state_d;
      step_idx_q    <= step_idx_d;
      chan_hold_q   <= chan_hold_d;
      step_strobe_q <= step_strobe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      tbl_q         <= tbl_d;
      dwell_q       <= dwell_d;
    end
  end

  assign chan_hold   = chan_hold_q;
  assign step_idx    = step_idx_q;
  assign step_strobe = step_strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_rgb_breathe_sched.sv
// Directed bench for rgb_breathe_sched with hand-computed per-cycle expectations.
module tb_rgb_breathe_sched;

  localparam int unsigned DWELL_W = 32;
  localparam int unsigned TB_DEFAULT_DWELL = 5;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic               stop;
  logic               pause;
  logic               loop_en;
  logic [1:0]         last_step;
  logic               tbl_we;
  logic [1:0]         tbl_addr;
  logic [2:0]         tbl_wdata;
  logic               dwell_we;
  logic [DWELL_W-1:0] dwell_wdata;
  logic [2:0]         chan_hold;
  logic [1:0]         step_idx;
  logic               step_strobe;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] exp_tbl [4] = '{3'b011, 3'b101, 3'b110, 3'b111};

  rgb_breathe_sched #(
    .DWELL_W       (DWELL_W),
    .DEFAULT_DWELL (TB_DEFAULT_DWELL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .loop_en     (loop_en),
    .last_step   (last_step),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_wdata   (tbl_wdata),
    .dwell_we    (dwell_we),
    .dwell_wdata (dwell_wdata),
    .chan_hold   (chan_hold),
    .step_idx    (step_idx),
    .step_strobe (step_strobe),
    .busy        (busy),
    .done        (done)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] e_hold, input logic [1:0] e_idx,
                         input logic e_strobe, input logic e_busy, input logic e_done);
    check($sformatf("%s.hold", tag),   32'(chan_hold),   32'(e_hold));
    check($sformatf("%s.idx", tag),    32'(step_idx),    32'(e_idx));
    check($sformatf("%s.strobe", tag), 32'(step_strobe), 32'(e_strobe));
    check($sformatf("%s.busy", tag),   32'(busy),        32'(e_busy));
    check($sformatf("%s.done", tag),   32'(done),        32'(e_done));
  endtask

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dwell(input logic [DWELL_W-1:0] v);
    dwell_we    = 1'b1;
    dwell_wdata = v;
    tick();
    dwell_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    last_step = 2'd0; tbl_we = 1'b0; tbl_addr = 2'd0; tbl_wdata = 3'd0;
    dwell_we = 1'b0; dwell_wdata = '0;
    tick(); tick();
    chk_out("rst", 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
    chk_out("rst_idle", 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);

    // One-shot through the default table, 3 cycles per step
    set_dwell(32'd3);
    last_step = 2'd3; loop_en = 1'b0;
    pulse_start();
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) tick();
      if (k < 12)
        chk_out($sformatf("oneshot%0d", k), exp_tbl[k/3], 2'(k/3), (k > 0 && k % 3 == 0), 1'b1, 1'b0);
      else if (k == 12)
        chk_out("oneshot12", 3'b111, 2'd0, 1'b0, 1'b0, 1'b1);
      else
        chk_out("oneshot13", 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // Looping over two steps, 2 cycles each, then stop
    set_dwell(32'd2);
    last_step = 2'd1; loop_en = 1'b1;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk_out($sformatf("loop%0d", k), exp_tbl[(k/2)%2], 2'((k/2)%2), (k > 0 && k % 2 == 0), 1'b1, 1'b0);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("loop_stop", 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);

    // Pause: 4 counting cycles plus 5 frozen cycles before done
    set_dwell(32'd4);
    last_step = 2'd0; loop_en = 1'b0;
    pulse_start();
    chk_out("pause0", 3'b011, 2'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      pause = (k >= 2 && k <= 5);
      tick();
      if (k < 9) chk_out($sformatf("pause%0d", k), 3'b011, 2'd0, 1'b0, 1'b1, 1'b0);
      else       chk_out("pause9", 3'b111, 2'd0, 1'b0, 1'b0, 1'b1);
    end
    pause = 1'b0;

    // Stop mid step 1, then start+stop together in IDLE
    set_dwell(32'd3);
    last_step = 2'd3; loop_en = 1'b0;
    pulse_start();
    for (int k = 1; k <= 4; k++) tick();
    chk_out("stop_pre", 3'b101, 2'd1, 1'b0, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("stop_now", 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("stop_after%0d", k), 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);
    end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk_out("startstop0", 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("startstop1", 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);

    // Dwell 0 written during step 0; table entry 1 written on its own load edge
    last_step = 2'd2; loop_en = 1'b0;
    pulse_start();
    dwell_we = 1'b1; dwell_wdata = '0; tick(); dwell_we = 1'b0;
    chk_out("dw0_e1", 3'b011, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("dw0_e2", 3'b011, 2'd0, 1'b0, 1'b1, 1'b0);
    tbl_we = 1'b1; tbl_addr = 2'd1; tbl_wdata = 3'b000; tick(); tbl_we = 1'b0;
    chk_out("dw0_e3", 3'b101, 2'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("dw0_e4", 3'b110, 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("dw0_e5", 3'b111, 2'd0, 1'b0, 1'b0, 1'b1);

    // Rerun with 1-cycle steps: entry 1 now holds the written value
    pulse_start();
    chk_out("wr_e0", 3'b011, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("wr_e1", 3'b000, 2'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("wr_e2", 3'b110, 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("wr_e3", 3'b111, 2'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-step overrides start and writes, restores table and dwell
    last_step = 2'd3; loop_en = 1'b1;
    pulse_start();
    tick();
    reset_n = 1'b0; start = 1'b1; tbl_we = 1'b1; tbl_addr = 2'd0; tbl_wdata = 3'b000;
    dwell_we = 1'b1; dwell_wdata = 32'd7;
    tick();
    chk_out("rst_mid", 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1; start = 1'b0; tbl_we = 1'b0; dwell_we = 1'b0;
    last_step = 2'd1; loop_en = 1'b0;
    tick();
    chk_out("rst_mid_idle", 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    chk_out("dflt_e0", 3'b011, 2'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4)  chk_out("dflt_e4", 3'b011, 2'd0, 1'b0, 1'b1, 1'b0);
      if (k == 5)  chk_out("dflt_e5", 3'b101, 2'd1, 1'b1, 1'b1, 1'b0);
      if (k == 9)  chk_out("dflt_e9", 3'b101, 2'd1, 1'b0, 1'b1, 1'b0);
      if (k == 10) chk_out("dflt_e10", 3'b111, 2'd0, 1'b0, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
